// File: rtl/io_pkg.sv
// Shared definitions for the input interface: request-state enumeration,
// write-back data width and the default switch-bank width.
package io_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int SW_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } io_state_e;

endpackage

// File: rtl/input_interface_if.sv
// Handshake bundle between the CPU side / user I/O and input_interface.
//   InReq      : input-read instruction active
//   Switches   : raw switch bank
//   ConfirmBtn : raw confirm pushbutton
//   InData     : captured switches, zero-extended
//   InValid    : one-cycle strobe qualifying InData
//   Stall      : freezes PC / register write while high
//   Waiting    : LED, high while waiting for a press
// master drives requests and user inputs; slave is the input_interface block.
interface input_interface_if #(
  parameter int SW_WIDTH = io_pkg::SW_WIDTH_DEF
);
  import io_pkg::*;

  logic                  InReq;
  logic [SW_WIDTH-1:0]   Switches;
  logic                  ConfirmBtn;
  logic [DATA_WIDTH-1:0] InData;
  logic                  InValid;
  logic                  Stall;
  logic                  Waiting;

  modport master (
    output InReq, Switches, ConfirmBtn,
    input  InData, InValid, Stall, Waiting
  );

  modport slave (
    input  InReq, Switches, ConfirmBtn,
    output InData, InValid, Stall, Waiting
  );

endinterface

// File: rtl/btn_debounce.sv
// Confirm-button conditioning: two-flop synchronizer, optional debouncer and
// rising-edge detector producing a one-cycle Press event.
// Ports: Clk, Rst_n (async, active-low), BtnRaw (raw button), Press (event).
// Macro INPUT_DEBOUNCE_EN: when defined, the synchronized level must differ
// from the debounced level for DEBOUNCE_CYCLES consecutive cycles before the
// debounced level follows it. When undefined, the synchronized level is used
// directly and DEBOUNCE_CYCLES has no effect.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic BtnRaw,
  output logic Press
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic level;

  always_comb begin
    sync1_d = BtnRaw;
    sync2_d = sync1_q;
    prev_d  = level;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

`ifdef INPUT_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts consecutive mismatch cycles; any matching cycle restarts it.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign level = deb_q;
`else
  assign level = sync2_q;
`endif

  // Release produces no event.
  assign Press = level & ~prev_q;

endmodule

// File: rtl/input_interface.sv
// Input-read unit: stalls the processor on an input instruction until the
// user confirms with a fresh button press, then delivers the switch bank
// (zero-extended) with a one-cycle InValid strobe.
// Ports: Clk, Rst_n (async, active-low), io (input_interface_if.slave).
// Macro INPUT_DEBOUNCE_EN selects the debounced button path (see btn_debounce).
//
// state | meaning
// IDLE  | no request pending; InReq starts one
// WAIT  | request pending, waiting for a press; InReq low aborts
// DONE  | capture delivered, InValid high for this cycle only
module input_interface
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SW_WIDTH        = SW_WIDTH_DEF
) (
  input logic             Clk,
  input logic             Rst_n,
  input_interface_if.slave io
);

  logic                  press;
  logic [SW_WIDTH-1:0]   sw;
  io_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] in_data_q, in_data_d;
  logic                  in_valid_q, in_valid_d;
  logic                  waiting_q, waiting_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .BtnRaw (io.ConfirmBtn),
    .Press  (press)
  );

  assign sw = io.Switches;

  always_comb begin
    state_d   = state_q;
    in_data_d = in_data_q;
    unique case (state_q)
      IDLE: if (io.InReq) state_d = WAIT;
      WAIT: begin
        // Abort wins over a coincident press.
        if (!io.InReq) begin
          state_d = IDLE;
        end else if (press) begin
          state_d   = DONE;
          in_data_d = DATA_WIDTH'(sw);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    in_valid_d = (state_d == DONE);
    waiting_d  = (state_d == WAIT);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      in_data_q  <= '0;
      in_valid_q <= 1'b0;
      waiting_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_data_q  <= in_data_d;
      in_valid_q <= in_valid_d;
      waiting_q  <= waiting_d;
    end
  end

  assign io.Stall   = ((state_q == IDLE) && io.InReq) || (state_q == WAIT);
  assign io.InData  = in_data_q;
  assign io.InValid = in_valid_q;
  assign io.Waiting = waiting_q;

endmodule

// File: doc/input_interface.md
INPUT_INTERFACE -- requirements
Module: input_interface

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000; the number of consecutive stable cycles required to accept a button level change.
REQ-002 SHALL have parameter SW_WIDTH, default 16; the width of the switch bank.
REQ-003 SHALL have port Clk, input, 1 bit; the single clock, rising-edge.
REQ-004 SHALL have port Rst_n, input, 1 bit; reset, asynchronous, active-low.
REQ-005 SHALL have port InReq, input, 1 bit; from ControlUnit decode, high while the current instruction is an input-read.
REQ-006 SHALL have port Switches, input, SW_WIDTH bits; raw switch bank, quasi-static.
REQ-007 SHALL have port ConfirmBtn, input, 1 bit; raw asynchronous confirm pushbutton, high = pressed.
REQ-008 SHALL have port InData, output, 32 bits; value delivered to ProcessUnit register write-back.
REQ-009 SHALL have port InValid, output, 1 bit; one-cycle strobe qualifying InData.
REQ-010 SHALL have port Stall, output, 1 bit; holds the ProcessUnit PC and register write while high.
REQ-011 SHALL have port Waiting, output, 1 bit; user LED, high while waiting for a button press.

Function
REQ-012 SHALL synchronize ConfirmBtn through two flops before any other use.
REQ-013 SHALL maintain a debounced level that toggles only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch gap SHALL restart the count.
REQ-014 SHALL generate a press event for one cycle when the debounced level rises 0->1; release SHALL generate no event.
REQ-015 SHALL implement the states IDLE, WAIT, and DONE.
REQ-016 IDLE: with InReq=1, SHALL go to WAIT; otherwise SHALL stay.
REQ-017 WAIT: on a press event, SHALL capture Switches and go to DONE; otherwise SHALL stay. InReq=0 in WAIT SHALL abort the request and return to IDLE without capturing.
REQ-018 DONE: SHALL go to IDLE unconditionally after one cycle; InReq SHALL be ignored in DONE.
REQ-019 Stall SHALL be combinational: (IDLE and InReq) or WAIT; Stall SHALL be 0 in DONE.
REQ-020 InValid SHALL be 1 exactly in DONE; InData SHALL hold the last captured value, and SHALL only be updated on capture.
REQ-021 InData SHALL be the captured Switches zero-extended to 32 bits.
REQ-022 Waiting SHALL be 1 exactly in WAIT.
REQ-023 A button already held when WAIT is entered SHALL NOT be accepted; a fresh debounced rising edge SHALL be required.
REQ-024 Back-to-back input instructions SHALL each require a separate press.
REQ-025 Latency from a clean ConfirmBtn rise to InValid SHALL be 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.

Reset
REQ-026 Rst_n low SHALL asynchronously force state IDLE, sync flops 0, debounced level 0, debounce counter 0, InData 0, InValid 0, and Waiting 0.
REQ-027 Reset asserted mid-WAIT or mid-DONE SHALL discard the pending request; no InValid SHALL follow deassertion unless a new InReq and press occur.

Configuration
REQ-028 With macro INPUT_DEBOUNCE_EN defined, the debounce logic of REQ-013 SHALL be present.
REQ-029 Without INPUT_DEBOUNCE_EN, the debounced level SHALL equal the synchronized level directly, giving a press-to-InValid latency of 3 cycles, and DEBOUNCE_CYCLES SHALL be unused.

Structure
REQ-030 Package io_pkg SHALL hold the state enumeration (IDLE, WAIT, DONE), the DATA_WIDTH=32 constant, and the default SW_WIDTH.
REQ-031 The synchronizer, debouncer, and edge detector SHALL form the sub-module btn_debounce (ports Clk, Rst_n, BtnRaw, Press); the FSM and capture SHALL reside in input_interface.

Verification (bench: DEBOUNCE_CYCLES=4, INPUT_DEBOUNCE_EN defined unless stated)
REQ-032 Basic read: InReq=1 and Switches=16'hBEEF, then a clean press held 10 cycles -> Stall=1 and Waiting=1 during WAIT; InValid pulses once, 7 cycles after the press; InData=32'h0000BEEF; Stall=0 in the same cycle.
REQ-033 Bounce: ConfirmBtn toggles every 2 cycles for 20 cycles, then stays high -> no InValid during bouncing; exactly one InValid, 7 cycles after it settles.
REQ-034 Held button: ConfirmBtn high before InReq rises -> remains in WAIT, no capture; release then press -> one capture.
REQ-035 Reset mid-WAIT: pulse Rst_n low during WAIT, then press -> state IDLE, InData=0, no InValid.
REQ-036 Abort and back-to-back: InReq dropped in WAIT -> IDLE, InData unchanged; two consecutive requests with presses of 16'h0001 and 16'hFFFF -> InData=32'h00000001 then 32'h0000FFFF.
REQ-037 Build without INPUT_DEBOUNCE_EN: clean press -> InValid exactly 3 cycles after the ConfirmBtn rise.
